alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_flag_gen.sv | 92 +++++++++
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_AND = 4'd7,
    OP_OR  = 4'd8,
    OP_XOR = 4'd9,
    OP_MOV = 4'd10,
    OP_MVN = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } alu_state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational result selection: picks the raw result for the opcode, extends it to 2N bits
// and derives {Z,N,C,V} plus the error indication.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [3:0]     i_op,
  input  logic [N-2:0]   i_b_mag,
  input  logic [N:0]     i_sum,
  input  logic [N:0]     i_sub,
  input  logic [2*N-1:0] i_mul,
  input  logic [N:0]     i_div,
  input  logic [N:0]     i_mod,
  input  logic [N:0]     i_shl,
  input  logic [N:0]     i_shr,
  input  logic [N:0]     i_and,
  input  logic [N:0]     i_or,
  input  logic [N:0]     i_xor,
  input  logic [N:0]     i_mov,
  input  logic [N:0]     i_movn,
  output logic [2*N-1:0] o_data,
  output logic [3:0]     o_flags,
  output logic           o_err
);

  logic [2*N-1:0] w_data;
  logic           w_n;
  logic           w_c;
  logic           w_v;
  logic           w_err;
  logic           w_div_zero;

  // Both +0 and -0 divisors count as zero since only the magnitude matters.
  assign w_div_zero = (i_b_mag == '0);

  always_comb begin
    w_data = '0;
    w_n    = 1'b0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_err  = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_data = {{(N-1){i_sum[N]}}, i_sum};
        w_n    = i_sum[N];
        w_c    = i_sum[N];
        w_v    = i_sum[N] ^ i_sum[N-1];
      end
      OP_SUB: begin
        w_data = {{(N-1){i_sub[N]}}, i_sub};
        w_n    = i_sub[N];
        w_c    = i_sub[N];
        w_v    = i_sub[N] ^ i_sub[N-1];
      end
      OP_MUL: begin
        w_data = i_mul;
        w_n    = i_mul[2*N-1];
      end
      OP_DIV: begin
        w_err  = w_div_zero;
        w_data = {{(N-1){i_div[N]}}, i_div};
        w_n    = i_div[N];
      end
      OP_MOD: begin
        w_err  = w_div_zero;
        w_data = {{(N-1){i_mod[N]}}, i_mod};
        w_n    = i_mod[N];
      end
      OP_SHL:  w_data = {{(N-1){1'b0}}, i_shl};
      OP_SHR:  w_data = {{(N-1){1'b0}}, i_shr};
      OP_AND:  w_data = {{(N-1){1'b0}}, i_and};
      OP_OR:   w_data = {{(N-1){1'b0}}, i_or};
      OP_XOR:  w_data = {{(N-1){1'b0}}, i_xor};
      OP_MOV:  w_data = {{(N-1){1'b0}}, i_mov};
      OP_MVN:  w_data = {{(N-1){1'b0}}, i_movn};
      default: w_err  = 1'b1;
    endcase
  end

  // Any error forces a zero result, which in turn reports only the Z flag.
  always_comb begin
    o_err           = w_err;
    o_data          = w_err ? '0 : w_data;
    o_flags         = '0;
    o_flags[FLAG_Z] = (o_data == '0);
    o_flags[FLAG_N] = w_n & ~w_err;
    o_flags[FLAG_C] = w_c & ~w_err;
    o_flags[FLAG_V] = w_v & ~w_err;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one command, drives registered operands to the operations unit,
// captures the selected result one cycle later and holds it until the consumer takes it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N     = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [N:0]       sum_i,
  input  logic [N:0]       sub_i,
  input  logic [2*N-1:0]   mul_i,
  input  logic [N:0]       div_i,
  input  logic [N:0]       mod_i,
  input  logic [N:0]       shl_i,
  input  logic [N:0]       shr_i,
  input  logic [N:0]       and_i,
  input  logic [N:0]       or_i,
  input  logic [N:0]       xor_i,
  input  logic [N:0]       mov_i,
  input  logic [N:0]       movn_i,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  alu_state_e       r_state;
  logic [3:0]       r_op;
  logic [N-1:0]     r_alu_a;
  logic [N-1:0]     r_alu_b;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [2*N-1:0]   r_rsp_data;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;

  logic [2*N-1:0]   w_data;
  logic [3:0]       w_flags;
  logic             w_err;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .i_op    (r_op),
    .i_b_mag (r_alu_b[N-2:0]),
    .i_sum   (sum_i),
    .i_sub   (sub_i),
    .i_mul   (mul_i),
    .i_div   (div_i),
    .i_mod   (mod_i),
    .i_shl   (shl_i),
    .i_shr   (shr_i),
    .i_and   (and_i),
    .i_or    (or_i),
    .i_xor   (xor_i),
    .i_mov   (mov_i),
    .i_movn  (movn_i),
    .o_data  (w_data),
    .o_flags (w_flags),
    .o_err   (w_err)
  );

  // The operand registers double as the latched command, so they stay frozen until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_alu_a     <= cmd_a;
            r_alu_b     <= cmd_b;
            r_cmd_ready <= 1'b0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rsp_data  <= w_data;
          r_rsp_flags <= w_flags;
          r_rsp_err   <= w_err;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_op_count  <= r_op_count + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_flags = r_rsp_flags;
  assign rsp_err   = r_rsp_err;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed and random commands checked against a
// sign-magnitude arithmetic reference model, with a small operations-unit model driving the raw results.
module tb_alu_issue_ctrl;

  localparam int N     = 6;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [N-1:0]     cmd_a;
  logic [N-1:0]     cmd_b;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [N:0]       sum_i, sub_i, div_i, mod_i, shl_i, shr_i, and_i, or_i, xor_i, mov_i, movn_i;
  logic [2*N-1:0]   mul_i;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*N-1:0]   rsp_data;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;

  int totalCount = 0;
  int badCount   = 0;
  int expCount   = 0;

  alu_issue_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .sum_i     (sum_i),
    .sub_i     (sub_i),
    .mul_i     (mul_i),
    .div_i     (div_i),
    .mod_i     (mod_i),
    .shl_i     (shl_i),
    .shr_i     (shr_i),
    .and_i     (and_i),
    .or_i      (or_i),
    .xor_i     (xor_i),
    .mov_i     (mov_i),
    .movn_i    (movn_i),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Sign-magnitude operand to signed integer.
  function automatic int smToInt(input logic [N-1:0] v);
    int mag;
    mag = int'(v[N-2:0]);
    return v[N-1] ? -mag : mag;
  endfunction

  // Operations-unit model: plain integer arithmetic on the registered operands.
  int ouA, ouB, ouSum, ouSub, ouMul, ouDiv, ouMod, ouShl;
  always_comb begin
    ouA   = smToInt(alu_a);
    ouB   = smToInt(alu_b);
    ouSum = ouA + ouB;
    ouSub = ouA - ouB;
    ouMul = ouA * ouB;
    ouDiv = (ouB != 0) ? ouA / ouB : 0;
    ouMod = (ouB != 0) ? ouA % ouB : 0;
    ouShl = int'(alu_a) << int'(alu_b[2:0]);
    sum_i  = ouSum[N:0];
    sub_i  = ouSub[N:0];
    mul_i  = ouMul[2*N-1:0];
    div_i  = ouDiv[N:0];
    mod_i  = ouMod[N:0];
    shl_i  = ouShl[N:0];
    shr_i  = {1'b0, alu_a >> alu_b[2:0]};
    and_i  = {1'b0, alu_a & alu_b};
    or_i   = {1'b0, alu_a | alu_b};
    xor_i  = {1'b0, alu_a ^ alu_b};
    mov_i  = {1'b0, alu_a};
    movn_i = {1'b0, ~alu_a};
  end

  // Reference: expected response from the opcode semantics on signed values.
  task automatic refModel(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [2*N-1:0] d, output logic [3:0] f, output logic e);
    int sa, sb, r;
    logic nf, cf, vf;
    sa = smToInt(a);
    sb = smToInt(b);
    r  = 0;
    nf = 1'b0; cf = 1'b0; vf = 1'b0; e = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        r  = (op == 4'd0) ? sa + sb : sa - sb;
        nf = (r < 0);
        cf = (r < 0);
        vf = (r > 31) || (r < -32);
      end
      4'd2: begin r = sa * sb; nf = (r < 0); end
      4'd3, 4'd4: begin
        if (sb == 0) e = 1'b1;
        else begin
          r  = (op == 4'd3) ? sa / sb : sa % sb;
          nf = (r < 0);
        end
      end
      4'd5:  r = (int'(a) << int'(b[2:0])) & 127;
      4'd6:  r = int'(a) >> int'(b[2:0]);
      4'd7:  r = int'(a & b);
      4'd8:  r = int'(a | b);
      4'd9:  r = int'(a ^ b);
      4'd10: r = int'(a);
      4'd11: r = (~int'(a)) & 63;
      default: e = 1'b1;
    endcase
    if (e) begin
      d = '0;
      f = 4'b1000;
    end else begin
      d = r[2*N-1:0];
      f = {(d == '0), nf, cf, vf};
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One full command: handshake, latency check, optional stall with ignored commands, response handshake.
  task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                               input int holdCycles);
    logic [2*N-1:0] ed;
    logic [3:0]     ef;
    logic           ee;
    int             waitCnt;
    refModel(op, a, b, ed, ef, ee);
    waitCnt = 0;
    while (!cmd_ready && waitCnt < 10) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("cmdReadyIdle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b;
    checkOutput("issueNoValid", 32'(rsp_valid), 32'd0);
    checkOutput("issueNotReady", 32'(cmd_ready), 32'd0);
    checkOutput("issueAluA", 32'(alu_a), 32'(a));
    checkOutput("issueAluB", 32'(alu_b), 32'(b));
    @(posedge clk); #1;
    checkOutput("rspValid", 32'(rsp_valid), 32'd1);
    checkOutput("rspData", 32'(rsp_data), 32'(ed));
    checkOutput("rspFlags", 32'(rsp_flags), 32'(ef));
    checkOutput("rspErr", 32'(rsp_err), 32'(ee));
    for (int i = 0; i < holdCycles; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 4'($urandom);
      cmd_a     = N'($urandom);
      cmd_b     = N'($urandom);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checkOutput("holdValid", 32'(rsp_valid), 32'd1);
      checkOutput("holdData", 32'(rsp_data), 32'(ed));
      checkOutput("holdFlags", 32'(rsp_flags), 32'(ef));
      checkOutput("holdErr", 32'(rsp_err), 32'(ee));
      checkOutput("holdNotReady", 32'(cmd_ready), 32'd0);
      checkOutput("holdAluA", 32'(alu_a), 32'(a));
      checkOutput("holdCount", 32'(op_count), 32'(expCount));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    expCount  = (expCount + 1) % (1 << CNT_W);
    checkOutput("doneValid", 32'(rsp_valid), 32'd0);
    checkOutput("doneReady", 32'(cmd_ready), 32'd1);
    checkOutput("doneCount", 32'(op_count), 32'(expCount));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstReady", 32'(cmd_ready), 32'd1);
    checkOutput("rstValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstData", 32'(rsp_data), 32'd0);
    checkOutput("rstFlags", 32'(rsp_flags), 32'd0);
    checkOutput("rstErr", 32'(rsp_err), 32'd0);
    checkOutput("rstAluA", 32'(alu_a), 32'd0);
    checkOutput("rstAluB", 32'(alu_b), 32'd0);
    checkOutput("rstCount", 32'(op_count), 32'd0);

    applyStimulus(4'd0, 6'b000011, 6'b000101, 0);
    checkOutput("addAnchor", 32'(rsp_data), 32'd8);
    applyStimulus(4'd1, 6'b000011, 6'b000101, 0);
    applyStimulus(4'd3, 6'b000111, 6'b100000, 0);
    applyStimulus(4'd4, 6'b100111, 6'b000000, 1);
    applyStimulus(4'd2, 6'b111111, 6'b011111, 5);
    applyStimulus(4'd0, 6'b011111, 6'b011111, 0);
    applyStimulus(4'd1, 6'b111111, 6'b011111, 0);
    applyStimulus(4'hE, 6'b000001, 6'b000010, 0);

    // Reset while the next command is in ISSUE must drop it entirely.
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 6'd1; cmd_b = 6'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expCount = 0;
    checkOutput("abortValid", 32'(rsp_valid), 32'd0);
    checkOutput("abortCount", 32'(op_count), 32'd0);
    checkOutput("abortReady", 32'(cmd_ready), 32'd1);
    checkOutput("abortAluA", 32'(alu_a), 32'd0);
    @(posedge clk); #1;
    checkOutput("abortStillIdle", 32'(rsp_valid), 32'd0);

    // Random traffic; more than 2^CNT_W handshakes so the counter wraps.
    for (int t = 0; t < 40; t++) begin
      applyStimulus(4'($urandom_range(0, 15)), N'($urandom), N'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
